// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: combinational reads, clocked byte/half/word writes,
// post-reset clear sweep, word loader port and sticky out-of-range error. Define DMEM_ALIGN_CHECK_EN to reject misaligned core writes.
module data_memory #(
   parameter int SIZE = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_rd_addr,
   output logic [31:0] data_rd_data,
   input  logic [1:0]  data_wr,
   input  logic [31:0] data_wr_addr,
   input  logic [31:0] data_wr_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        busy,
   output logic        err,
   output logic [31:0] err_addr
);

   localparam int AW = $clog2(SIZE);
   localparam int CW = (SIZE / 4 > 1) ? $clog2(SIZE / 4) : 1;
   localparam logic [32:0]   SIZE33   = 33'(SIZE);
   localparam logic [CW-1:0] CNT_LAST = CW'(SIZE / 4 - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [31:0]   err_addr_q, err_addr_d;
   logic [7:0]    mem_q [SIZE];
   logic [7:0]    mem_d [SIZE];

   logic [2:0]    core_n;
   logic [32:0]   core_end;
   logic          core_oob;
   logic          core_mis;
   logic          core_req;
   logic          core_we;
   logic          core_err;
   logic [32:0]   ld_base;
   logic          ld_oob;
   logic          ld_fire;
   logic          ld_we;
   logic          ld_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Storage needs no reset: the sweep zeroes it before anything can observe it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign ld_ready = (state_q == READY);
   assign err      = err_q;
   assign err_addr = err_addr_q;

   always_comb begin
      case (data_wr)
         2'd1:    core_n = 3'd1;
         2'd2:    core_n = 3'd2;
         default: core_n = 3'd4;
      endcase
   end

   // Range checks use 33-bit sums so an access near 2^32 cannot wrap back into memory.
   assign core_end = {1'b0, data_wr_addr} + 33'(core_n) - 33'd1;
   assign core_oob = (core_end >= SIZE33);
`ifdef DMEM_ALIGN_CHECK_EN
   assign core_mis = ((data_wr == 2'd2) && data_wr_addr[0]) ||
                     ((data_wr == 2'd3) && (data_wr_addr[1:0] != 2'b00));
`else
   assign core_mis = 1'b0;
`endif
   assign core_req = ld_ready && (data_wr != 2'd0);
   assign core_we  = core_req && !core_oob && !core_mis;
   assign core_err = core_req && (core_oob || core_mis);

   assign ld_base = {1'b0, ld_addr[31:2], 2'b00};
   assign ld_oob  = ((ld_base + 33'd3) >= SIZE33);
   assign ld_fire = ld_valid && ld_ready;
   assign ld_we   = ld_fire && !ld_oob;
   assign ld_err  = ld_fire && ld_oob;

   always_comb begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (core_err || ld_err) begin
         err_d = 1'b1;
         if (!err_q) begin
            err_addr_d = core_err ? data_wr_addr : ld_addr;
         end
      end
   end

   // Loader bytes land first so that overlapping core bytes overwrite them.
   always_comb begin
      logic [AW-1:0] clr_idx;
      logic [AW-1:0] ld_idx;
      logic [AW-1:0] core_idx;
      clr_idx  = AW'({cnt_q, 2'b00});
      ld_idx   = ld_addr[AW-1:0] & ~AW'(3);
      core_idx = data_wr_addr[AW-1:0];
      mem_d    = mem_q;
      if (busy) begin
         for (int k = 0; k < 4; k++) begin
            mem_d[clr_idx + AW'(k)] = 8'h00;
         end
      end
      if (ld_we) begin
         for (int k = 0; k < 4; k++) begin
            mem_d[ld_idx + AW'(k)] = ld_data[8*k +: 8];
         end
      end
      if (core_we) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(core_n)) begin
               mem_d[core_idx + AW'(k)] = data_wr_data[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      logic [32:0] rd_byte_addr;
      data_rd_data = '0;
      rd_byte_addr = '0;
      if (!busy) begin
         for (int k = 0; k < 4; k++) begin
            rd_byte_addr = {1'b0, data_rd_addr} + 33'(k);
            if (rd_byte_addr < SIZE33) begin
               data_rd_data[8*k +: 8] = mem_q[data_rd_addr[AW-1:0] + AW'(k)];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: table of single-write/read vectors plus
// hand-written sequences for reset sweep timing, same-cycle read-after-write and mid-sweep reset.
module tb_data_memory;

   localparam int SIZE = 1024;
   localparam int SWEEP = SIZE / 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_rd_addr;
   logic [31:0] data_rd_data;
   logic [1:0]  data_wr;
   logic [31:0] data_wr_addr;
   logic [31:0] data_wr_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        busy;
   logic        err;
   logic [31:0] err_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory #(.SIZE(SIZE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_rd_addr (data_rd_addr),
      .data_rd_data (data_rd_data),
      .data_wr      (data_wr),
      .data_wr_addr (data_wr_addr),
      .data_wr_data (data_wr_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .busy         (busy),
      .err          (err),
      .err_addr     (err_addr)
   );

   typedef struct {
      string       name;
      logic [1:0]  wr;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic        ldv;
      logic [31:0] ld_addr;
      logic [31:0] ld_data;
      logic [31:0] rd_addr;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] exp_ea;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic addVec(input string name, input logic [1:0] wr, input logic [31:0] wa,
                         input logic [31:0] wd, input logic ldv, input logic [31:0] la,
                         input logic [31:0] ldd, input logic [31:0] ra, input logic [31:0] er,
                         input logic ee, input logic [31:0] ea);
      vec_t v;
      v.name = name; v.wr = wr; v.wr_addr = wa; v.wr_data = wd;
      v.ldv = ldv; v.ld_addr = la; v.ld_data = ldd;
      v.rd_addr = ra; v.exp_rd = er; v.exp_err = ee; v.exp_ea = ea;
      vecs.push_back(v);
   endtask

   // One write cycle, then the read address is presented and everything is sampled at the next negedge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      data_wr      = v.wr;
      data_wr_addr = v.wr_addr;
      data_wr_data = v.wr_data;
      ld_valid     = v.ldv;
      ld_addr      = v.ld_addr;
      ld_data      = v.ld_data;
      @(posedge clk);
      #1;
      data_wr      = 2'd0;
      ld_valid     = 1'b0;
      data_rd_addr = v.rd_addr;
      @(negedge clk);
      checkOutput({v.name, "/rd"}, data_rd_data, v.exp_rd);
      checkOutput({v.name, "/err"}, 32'(err), 32'(v.exp_err));
      checkOutput({v.name, "/err_addr"}, err_addr, v.exp_ea);
   endtask

   task automatic waitSweep(input string name);
      int cycles = 0;
      while (busy === 1'b1 && cycles < 4 * SWEEP) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({name, "/cycles"}, 32'(cycles), 32'(SWEEP));
      checkOutput({name, "/ld_ready"}, 32'(ld_ready), 32'd1);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, "/busy"}, 32'(busy), 32'd1);
      checkOutput({name, "/ld_ready"}, 32'(ld_ready), 32'd0);
      checkOutput({name, "/err"}, 32'(err), 32'd0);
      checkOutput({name, "/err_addr"}, err_addr, 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      data_rd_addr = 32'h0;
      data_wr      = 2'd0;
      data_wr_addr = 32'h0;
      data_wr_data = 32'h0;
      ld_valid     = 1'b0;
      ld_addr      = 32'h0;
      ld_data      = 32'h0;

      addVec("word10",   2'd3, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
      addVec("rd11",     2'd0, 32'h0, 32'h0, 0, 0, 0, 32'h11, 32'h00DEADBE, 0, 32'h0);
      addVec("byte12",   2'd1, 32'h12, 32'h123456AB, 0, 0, 0, 32'h10, 32'hDEABBEEF, 0, 32'h0);
      addVec("half10",   2'd2, 32'h10, 32'h9ABC5678, 0, 0, 0, 32'h10, 32'hDEAB5678, 0, 32'h0);
      addVec("word0",    2'd3, 32'h0, 32'h44332211, 0, 0, 0, 32'h0, 32'h44332211, 0, 32'h0);
      addVec("rdwrap",   2'd0, 32'h0, 32'h0, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 0, 32'h0);
      addVec("byte3ff",  2'd1, 32'h3FF, 32'h00000077, 0, 0, 0, 32'h3FC, 32'h77000000, 0, 32'h0);
      addVec("word3fe",  2'd3, 32'h3FE, 32'hCAFEF00D, 0, 0, 0, 32'h3FC, 32'h77000000, 1, 32'h3FE);
      addVec("byte500",  2'd1, 32'h500, 32'h000000FF, 0, 0, 0, 32'h3FE, 32'h00007700, 1, 32'h3FE);
      addVec("half3ff",  2'd2, 32'h3FF, 32'h0000BBAA, 0, 0, 0, 32'h3FF, 32'h00000077, 1, 32'h3FE);
      addVec("wordwrap", 2'd3, 32'hFFFFFFFE, 32'h55555555, 0, 0, 0, 32'h0, 32'h44332211, 1, 32'h3FE);
      addVec("ldcore",   2'd3, 32'h20, 32'hAABBCCDD, 1, 32'h23, 32'h11223344, 32'h20, 32'hAABBCCDD, 1, 32'h3FE);
      addVec("ldbyte",   2'd1, 32'h29, 32'h000000EE, 1, 32'h28, 32'h11223344, 32'h28, 32'h1122EE44, 1, 32'h3FE);
      addVec("ldalone",  2'd0, 32'h0, 32'h0, 1, 32'h24, 32'h55667788, 32'h24, 32'h55667788, 1, 32'h3FE);
      addVec("ldoob",    2'd0, 32'h0, 32'h0, 1, 32'h400, 32'hDEADDEAD, 32'h3FC, 32'h77000000, 1, 32'h3FE);
      addVec("ldlast",   2'd0, 32'h0, 32'h0, 1, 32'h3FC, 32'h99887766, 32'h3FE, 32'h00009988, 1, 32'h3FE);
`ifdef DMEM_ALIGN_CHECK_EN
      addVec("unalign",  2'd3, 32'h31, 32'h01020304, 0, 0, 0, 32'h30, 32'h00000000, 1, 32'h3FE);
`else
      addVec("unalign",  2'd3, 32'h31, 32'h01020304, 0, 0, 0, 32'h30, 32'h02030400, 1, 32'h3FE);
`endif

      repeat (3) @(negedge clk);
      checkResetState("reset");
      checkOutput("reset/rd", data_rd_data, 32'h0);
      rst_n = 1'b1;
      waitSweep("sweep1");
      data_rd_addr = 32'h0;
      @(negedge clk);
      checkOutput("sweep1/rd0", data_rd_data, 32'h0);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Same-cycle read sees the old word; the new word appears after the edge.
      @(negedge clk);
      data_wr      = 2'd3;
      data_wr_addr = 32'h40;
      data_wr_data = 32'h13579BDF;
      data_rd_addr = 32'h40;
      #1;
      checkOutput("raw/same", data_rd_data, 32'h0);
      @(posedge clk);
      #1;
      data_wr = 2'd0;
      @(negedge clk);
      checkOutput("raw/next", data_rd_data, 32'h13579BDF);

      // Reset, run 100 sweep cycles, reset again mid-sweep and expect a full restart.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetState("rst2");
      rst_n        = 1'b1;
      data_rd_addr = 32'h10;
      #1;
      checkOutput("rst2/rd_busy", data_rd_data, 32'h0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      checkOutput("mid/busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetState("rst3");
      rst_n = 1'b1;
      waitSweep("sweep3");
      @(negedge clk);
      checkOutput("sweep3/rd10", data_rd_data, 32'h0);

      begin
         vec_t v;
         v.name = "align12"; v.wr = 2'd3; v.wr_addr = 32'h12; v.wr_data = 32'hA1B2C3D4;
         v.ldv = 1'b0; v.ld_addr = 32'h0; v.ld_data = 32'h0; v.rd_addr = 32'h10;
`ifdef DMEM_ALIGN_CHECK_EN
         v.exp_rd = 32'h00000000; v.exp_err = 1'b1; v.exp_ea = 32'h12;
`else
         v.exp_rd = 32'hC3D40000; v.exp_err = 1'b0; v.exp_ea = 32'h0;
`endif
         applyStimulus(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
